// File: rtl/core_pkg.sv
// Shared definitions for the 6502-subset core: opcodes, FSM states, flag bits, ALU ops.
// Optional feature macro used by the core: CORE_STORE_EN (adds STA zp).
package core_pkg;

  localparam logic [7:0] OP_NOP = 8'hEA;
  localparam logic [7:0] OP_CLC = 8'h18;
  localparam logic [7:0] OP_SEC = 8'h38;
  localparam logic [7:0] OP_LDA = 8'hA9;
  localparam logic [7:0] OP_LDX = 8'hA2;
  localparam logic [7:0] OP_LDY = 8'hA0;
  localparam logic [7:0] OP_AND = 8'h29;
  localparam logic [7:0] OP_ORA = 8'h09;
  localparam logic [7:0] OP_EOR = 8'h49;
  localparam logic [7:0] OP_ADC = 8'h69;
  localparam logic [7:0] OP_SBC = 8'hE9;
  localparam logic [7:0] OP_CMP = 8'hC9;
  localparam logic [7:0] OP_STA = 8'h85;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, WRITE} state_e;

  typedef enum logic [2:0] {
    ALU_LD, ALU_AND, ALU_ORA, ALU_EOR, ALU_ADC, ALU_SBC, ALU_CMP
  } alu_op_e;

  function automatic alu_op_e alu_op_of(input logic [7:0] op);
    case (op)
      OP_AND:  alu_op_of = ALU_AND;
      OP_ORA:  alu_op_of = ALU_ORA;
      OP_EOR:  alu_op_of = ALU_EOR;
      OP_ADC:  alu_op_of = ALU_ADC;
      OP_SBC:  alu_op_of = ALU_SBC;
      OP_CMP:  alu_op_of = ALU_CMP;
      default: alu_op_of = ALU_LD;
    endcase
  endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational ALU for the immediate-mode instructions; reports result, flags
// and which flags the selected operation is allowed to update.
module core_alu
  import core_pkg::*;
(
  input  alu_op_e    op,
  input  logic [7:0] a,
  input  logic [7:0] m,
  input  logic       c_in,
  output logic [7:0] result,
  output logic       n,
  output logic       z,
  output logic       c,
  output logic       v,
  output logic       upd_nz,
  output logic       upd_c,
  output logic       upd_v
);

  logic [7:0] m_eff;
  logic       cin_eff;
  logic [8:0] sum;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    // Subtraction is addition of the inverted operand; CMP ignores the carry in.
    m_eff   = (op == ALU_SBC || op == ALU_CMP) ? ~m : m;
    cin_eff = (op == ALU_CMP) ? 1'b1 : c_in;
    sum     = {1'b0, a} + {1'b0, m_eff} + 9'(cin_eff);
    result  = m;
    upd_nz  = 1'b1;
    upd_c   = 1'b0;
    upd_v   = 1'b0;
    case (op)
      ALU_AND: result = a & m;
      ALU_ORA: result = a | m;
      ALU_EOR: result = a ^ m;
      ALU_ADC, ALU_SBC: begin
        result = sum[7:0];
        upd_c  = 1'b1;
        upd_v  = 1'b1;
      end
      ALU_CMP: begin
        result = sum[7:0];
        upd_c  = 1'b1;
      end
      default: result = m;
    endcase
    n = result[7];
    z = (result == 8'h00);
    c = sum[8];
    v = (a[7] == m_eff[7]) && (result[7] != a[7]);
  end

endmodule

// File: rtl/cpu_core.sv
// Minimal 6502-subset core: FETCH/DECODE/EXEC over a registered-read RAM bus.
// Define CORE_STORE_EN to add STA zp (opcode 85) with a WRITE bus cycle.
module cpu_core
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        RW,
  output logic [15:0] AD,
  input  logic [7:0]  D_in,
  output logic [7:0]  D_out
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ad_q, ad_d;
  logic        rw_q, rw_d;
  logic [7:0]  a_q, a_d, x_q, x_d, y_q, y_d, ir_q, ir_d;
  logic [3:0]  flags_q, flags_d;

  logic [7:0] alu_result;
  logic       alu_n, alu_z, alu_c, alu_v;
  logic       upd_nz, upd_c, upd_v;

  function automatic logic two_byte(input logic [7:0] op);
    case (op)
      OP_LDA, OP_LDX, OP_LDY, OP_AND, OP_ORA,
      OP_EOR, OP_ADC, OP_SBC, OP_CMP: two_byte = 1'b1;
`ifdef CORE_STORE_EN
      OP_STA:                         two_byte = 1'b1;
`endif
      default:                        two_byte = 1'b0;
    endcase
  endfunction

  core_alu u_alu (
    .op     (alu_op_of(ir_q)),
    .a      (a_q),
    .m      (D_in),
    .c_in   (flags_q[FLAG_C]),
    .result (alu_result),
    .n      (alu_n),
    .z      (alu_z),
    .c      (alu_c),
    .v      (alu_v),
    .upd_nz (upd_nz),
    .upd_c  (upd_c),
    .upd_v  (upd_v)
  );

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= 16'h0000;
      ad_q    <= 16'h0000;
      rw_q    <= 1'b1;
      a_q     <= 8'h00;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      ir_q    <= 8'h00;
      flags_q <= 4'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ad_q    <= ad_d;
      rw_q    <= rw_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: state_d = two_byte(D_in) ? EXEC : FETCH;
`ifdef CORE_STORE_EN
      EXEC:   state_d = (ir_q == OP_STA) ? WRITE : FETCH;
`else
      EXEC:   state_d = FETCH;
`endif
      default: state_d = FETCH;
    endcase
  end

  // Register and flag updates; one-byte opcodes complete in DECODE.
  always_comb begin
    pc_d    = pc_q;
    a_d     = a_q;
    x_d     = x_q;
    y_d     = y_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    case (state_q)
      FETCH: pc_d = pc_q + 16'd1;
      DECODE: begin
        ir_d = D_in;
        if (two_byte(D_in))     pc_d = pc_q + 16'd1;
        else if (D_in == OP_CLC) flags_d[FLAG_C] = 1'b0;
        else if (D_in == OP_SEC) flags_d[FLAG_C] = 1'b1;
      end
      EXEC: begin
        if (ir_q != OP_STA) begin
          case (ir_q)
            OP_LDX:  x_d = alu_result;
            OP_LDY:  y_d = alu_result;
            OP_CMP:  a_d = a_q;
            default: a_d = alu_result;
          endcase
          if (upd_nz) begin
            flags_d[FLAG_N] = alu_n;
            flags_d[FLAG_Z] = alu_z;
          end
          if (upd_c) flags_d[FLAG_C] = alu_c;
          if (upd_v) flags_d[FLAG_V] = alu_v;
        end
      end
      default: ;
    endcase
  end

  // Bus outputs are registered from the next state, so AD only moves on edges.
  always_comb begin
    ad_d = pc_d;
    rw_d = 1'b1;
`ifdef CORE_STORE_EN
    if (state_d == WRITE) begin
      ad_d = {8'h00, D_in};
      rw_d = 1'b0;
    end
`endif
  end

  assign AD    = ad_q;
  assign RW    = rw_q;
  assign D_out = a_q;

endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: per-cycle expected bus/register records are queued
// by the stimulus and popped by a negedge monitor. Build with CORE_STORE_EN for STA.
module tb_cpu_core;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rw;
  logic [15:0] ad;
  logic [7:0]  d_in, d_out;

  always #5 clk = ~clk;

  cpu_core dut (
    .clk   (clk),
    .rst   (rst),
    .RW    (rw),
    .AD    (ad),
    .D_in  (d_in),
    .D_out (d_out)
  );

  // 1 KiB registered-read RAM with a bench-side load port.
  logic [7:0] mem [1024];
  logic       ld_en = 1'b0;
  logic [9:0] ld_addr = '0;
  logic [7:0] ld_data = '0;

  always @(posedge clk) begin
    d_in <= mem[ad[9:0]];
    if (ld_en)    mem[ld_addr] <= ld_data;
    else if (!rw) mem[ad[9:0]] <= d_out;
  end

  typedef struct packed {
    logic [15:0] ad;
    logic        rw;
    logic [7:0]  a;
    logic        regs;
    logic [15:0] pc;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_n   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] fl(input logic n, input logic z, input logic c, input logic v);
    logic [3:0] f;
    f = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  task automatic cyc(input logic [15:0] ad_e, input logic [7:0] a_e, input logic rw_e = 1'b1);
    exp_t e;
    e    = '0;
    e.ad = ad_e;
    e.a  = a_e;
    e.rw = rw_e;
    sb.push_back(e);
  endtask

  // Register check; only used in FETCH cycles, where AD equals PC.
  task automatic regs(input logic [15:0] ad_e, input logic [7:0] a_e, input logic [7:0] x_e,
                      input logic [7:0] y_e, input logic [3:0] f_e);
    exp_t e;
    e       = '0;
    e.ad    = ad_e;
    e.a     = a_e;
    e.rw    = 1'b1;
    e.regs  = 1'b1;
    e.pc    = ad_e;
    e.x     = x_e;
    e.y     = y_e;
    e.flags = f_e;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cyc_n++;
      check($sformatf("c%0d AD", cyc_n), 32'(ad), 32'(e.ad));
      check($sformatf("c%0d RW", cyc_n), 32'(rw), 32'(e.rw));
      check($sformatf("c%0d D_out", cyc_n), 32'(d_out), 32'(e.a));
      if (e.regs) begin
        check($sformatf("c%0d PC", cyc_n), 32'(dut.pc_q), 32'(e.pc));
        check($sformatf("c%0d X", cyc_n), 32'(dut.x_q), 32'(e.x));
        check($sformatf("c%0d Y", cyc_n), 32'(dut.y_q), 32'(e.y));
        check($sformatf("c%0d NZCV", cyc_n), 32'(dut.flags_q), 32'(e.flags));
        check($sformatf("c%0d state", cyc_n), 32'(dut.state_q), 32'(FETCH));
      end
    end
  end

  // Holds reset while loading the program, padded with NOPs up to 0x48.
  task automatic load_prog(input logic [7:0] p [$]);
    rst   = 1'b1;
    ld_en = 1'b1;
    for (int i = 0; i < 'h48; i++) begin
      ld_addr = 10'(i);
      ld_data = (i < p.size()) ? p[i] : OP_NOP;
      @(posedge clk);
      #1;
    end
    ld_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb.size() != 0 && b < 200) begin
      @(posedge clk);
      b++;
    end
    #1;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d records left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    // CE (undefined), LDA #55, ADC #03, AND #F0
    load_prog('{8'hCE, 8'hA9, 8'h55, 8'h69, 8'h03, 8'h29, 8'hF0});
    cyc(0, 0); cyc(1, 0); cyc(1, 0); cyc(2, 0); cyc(3, 0);
    cyc(3, 8'h55); cyc(4, 8'h55); cyc(5, 8'h55);
    cyc(5, 8'h58); cyc(6, 8'h58); cyc(7, 8'h58);
    regs(7, 8'h50, 0, 0, fl(0, 0, 0, 0));
    drain();

    // SEC, LDA #10, SBC #10, CMP #01, LDX #FF, LDY #00
    load_prog('{8'h38, 8'hA9, 8'h10, 8'hE9, 8'h10, 8'hC9, 8'h01,
                8'hA2, 8'hFF, 8'hA0, 8'h00});
    cyc(0, 0); cyc(1, 0); regs(1, 0, 0, 0, fl(0, 0, 1, 0));
    cyc(2, 0); cyc(3, 0); regs(3, 8'h10, 0, 0, fl(0, 0, 1, 0));
    cyc(4, 8'h10); cyc(5, 8'h10); regs(5, 8'h00, 0, 0, fl(0, 1, 1, 0));
    cyc(6, 0); cyc(7, 0); regs(7, 8'h00, 0, 0, fl(1, 0, 0, 0));
    cyc(8, 0); cyc(9, 0); regs(9, 8'h00, 8'hFF, 0, fl(1, 0, 0, 0));
    cyc(10, 0); cyc(11, 0); regs(11, 8'h00, 8'hFF, 8'h00, fl(0, 1, 0, 0));
    drain();

    // LDA #55, ADC #03 with reset asserted during the ADC EXEC cycle
    load_prog('{8'hA9, 8'h55, 8'h69, 8'h03});
    cyc(0, 0); cyc(1, 0); cyc(2, 0); cyc(2, 8'h55); cyc(3, 8'h55); cyc(4, 8'h55);
    regs(0, 8'h00, 0, 0, fl(0, 0, 0, 0));
    cyc(1, 0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drain();

    // LDA #7F, ADC #01: signed overflow into bit 7
    load_prog('{8'hA9, 8'h7F, 8'h69, 8'h01});
    cyc(0, 0); cyc(1, 0); cyc(2, 0); cyc(2, 8'h7F); cyc(3, 8'h7F); cyc(4, 8'h7F);
    regs(4, 8'h80, 0, 0, fl(1, 0, 0, 1));
    drain();

`ifdef CORE_STORE_EN
    // LDA #AB, STA 40
    load_prog('{8'hA9, 8'hAB, 8'h85, 8'h40});
    cyc(0, 0); cyc(1, 0); cyc(2, 0); cyc(2, 8'hAB); cyc(3, 8'hAB); cyc(4, 8'hAB);
    cyc(16'h0040, 8'hAB, 1'b0);
    regs(4, 8'hAB, 0, 0, fl(1, 0, 0, 0));
    drain();
    check("mem[40]", 32'(mem[10'h040]), 32'h0000_00AB);
`else
    // 85 decodes as a one-byte NOP when stores are not built in
    load_prog('{8'h85, 8'hEA});
    cyc(0, 0); cyc(1, 0); regs(1, 0, 0, 0, fl(0, 0, 0, 0)); cyc(2, 0);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
# cpu_core

Minimal 6502-subset CPU core. It fetches and executes immediate-mode accumulator/index instructions from a byte-wide synchronous RAM over a single shared address/data bus. It sits at the top of the CPU datapath. A separate `ram` model (1 KiB, registered read) is its only bus peer; the bus carries address AD, direction RW, read data D_in and write data D_out.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- RW  out  1  1 = read, 0 = write (write only with CORE_STORE_EN)
- AD  out  16  bus address
- D_in  in  8  read data from RAM (registered, valid the cycle after AD is presented)
- D_out  out  8  write data; always equals A

## Operation
- Registers: PC[15:0], A, X, Y, IR, flags N Z C V.
- Reset values: PC=0000, A=X=Y=00, N=Z=C=V=0, state FETCH, AD=0000, RW=1, D_out=00. No reset vector; execution starts at address 0000.
- States:
  - FETCH: AD=PC, PC<=PC+1 → DECODE.
  - DECODE: IR<=D_in, AD=PC. Two-byte opcode: PC<=PC+1 → EXEC. One-byte opcode: execute now → FETCH.
  - EXEC: operand=D_in, update registers/flags → FETCH.
- One-byte opcodes:
  - EA NOP.
  - 18 CLC.
  - 38 SEC.
  - Any undefined opcode (e.g. CE) executes as a 1-byte NOP with no state change.
- Immediate opcodes, M = operand:
  - A9 LDA, A2 LDX, A0 LDY: load register; set N Z.
  - 29 AND, 09 ORA, 49 EOR: A <= A op M; set N Z.
  - 69 ADC: A+M+C, 9-bit sum. C = bit 8. V = (A[7]==M[7]) && (R[7]!=A[7]). Set N Z.
  - E9 SBC: same as ADC with M replaced by ~M. Binary only; no decimal mode.
  - C9 CMP: R = A-M, A unchanged. C = (A>=M). Set N Z.
- N = result[7]; Z = (result==00).
- PC wraps FFFF→0000 silently.
- rst asserted in any state: next edge forces reset values, aborting the instruction in flight.
- RAM contract:
  - On each clk edge, `ram` latches mem[A] onto its D_out.
  - If RW=0, mem[A] <= D_in on the same edge; read-during-write returns the old data.
  - Only AD[9:0] decode the 1 KiB array; upper bits are ignored, so the array aliases.

## Timing
- NOP/CLC/SEC/undefined: 2 cycles (FETCH, DECODE).
- Immediate: 3 cycles. The result is visible in registers after the EXEC edge.
- STA zp (CORE_STORE_EN only): 4 cycles.
- AD changes only on clock edges; it is registered in state-decoded form, glitch-free to RAM.
- RW is 1 in every cycle except WRITE.

## Configuration
- CORE_STORE_EN defined: adds opcode 85 STA zp.
  - EXEC latches the operand, then → WRITE.
  - WRITE: AD={8'h00,operand}, RW=0, D_out=A → FETCH. Flags unaffected.
- CORE_STORE_EN undefined: 85 is 2-byte fetch? No: 85 decodes as an undefined 1-byte NOP, and RW is tied 1.

## Structure
- Package `core_pkg`: opcode localparams, state enum (FETCH, DECODE, EXEC, WRITE), flag bit indices.
- One sub-module `core_alu`: combinational.
  - Inputs: op select, A, M, C.
  - Outputs: result[7:0], N, Z, C, V, and per-op flag-update enables.
- `ram` is a separate top-level model, not part of the core.

## Test plan
- Reset then program CE, A9 55, 69 03, 29 F0 at 0000:
  - A=55 after cycle 5, A=58 after cycle 8, A=50 after cycle 11.
  - Final flags N=0 Z=0 C=0 V=0.
  - AD sequence 0,1,1,2,3,3,4,5,5,6.
- LDA #7F, ADC #01 → A=80, N=1 V=1 C=0 Z=0.
- SEC, LDA #10, SBC #10 → A=00, Z=1 C=1. Then CMP #01 → C=0 N=1, A remains 00.
- LDX #FF, LDY #00 → X=FF N=1. Then Y=00 Z=1.
- rst asserted during EXEC of ADC → PC=0000, A=00, state FETCH next cycle.
- With CORE_STORE_EN: LDA #AB, STA 40 → RW=0 for exactly one cycle with AD=0040, D_out=AB; afterwards RAM mem[40]=AB.
